// File: rtl/udma_ch_alloc.sv
// udma_ch_alloc: runtime linear-channel ID allocator for the uDMA core.
// Walks per-peripheral TX/RX channel counts one slot per cycle, builds
// contiguous base tables, then serves 1-cycle lookups (per,dir,sub)->id.
// Ports: clk_i/rst_i (sync, active-high); tx_cnt_i/rx_cnt_i packed counts;
// rebuild_i restart pulse; busy_o/map_ok_o/ovf_o status; tx_used_o/
// rx_used_o totals; req_* lookup request; rsp_* registered response.
// Option: define UDMA_CH_ALLOC_BOUNDS_EN to range-check the sub-index.
module udma_ch_alloc #(
  parameter int unsigned N_PERIPHS = 8,
  parameter int unsigned MAX_CH    = 4,
  parameter int unsigned N_TX_CH   = 16,
  parameter int unsigned N_RX_CH   = 16,
  localparam int unsigned CW  = $clog2(MAX_CH + 1),
  localparam int unsigned IDW =
    $clog2((N_TX_CH > N_RX_CH) ? N_TX_CH : N_RX_CH),
  localparam int unsigned PW  = $clog2(N_PERIPHS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_PERIPHS*CW-1:0] tx_cnt_i,
  input  logic [N_PERIPHS*CW-1:0] rx_cnt_i,
  input  logic                  rebuild_i,
  output logic                  busy_o,
  output logic                  map_ok_o,
  output logic                  ovf_o,
  output logic [IDW:0]          tx_used_o,
  output logic [IDW:0]          rx_used_o,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [PW:0]           req_per_i,
  input  logic                  req_dir_i,
  input  logic [CW-1:0]         req_sub_i,
  output logic                  rsp_valid_o,
  output logic [IDW-1:0]        rsp_id_o,
  output logic                  rsp_err_o
);

  localparam int unsigned ACW = IDW + 2;
  localparam int unsigned UW  = IDW + 1;
  localparam int unsigned PW1 = PW + 1;

  typedef enum logic [1:0] {
    BUILD = 2'd0,
    READY = 2'd1,
    OVF   = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  idx_q, idx_d;
  logic [ACW-1:0] tx_acc_q, tx_acc_d;
  logic [ACW-1:0] rx_acc_q, rx_acc_d;
  logic [IDW-1:0] tx_base_q [N_PERIPHS];
  logic [IDW-1:0] tx_base_d [N_PERIPHS];
  logic [IDW-1:0] rx_base_q [N_PERIPHS];
  logic [IDW-1:0] rx_base_d [N_PERIPHS];
`ifdef UDMA_CH_ALLOC_BOUNDS_EN
  logic [CW-1:0]  tx_len_q [N_PERIPHS];
  logic [CW-1:0]  tx_len_d [N_PERIPHS];
  logic [CW-1:0]  rx_len_q [N_PERIPHS];
  logic [CW-1:0]  rx_len_d [N_PERIPHS];
`endif
  logic [IDW:0]   tx_used_q, tx_used_d;
  logic [IDW:0]   rx_used_q, rx_used_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic           rsp_err_q, rsp_err_d;

  logic [CW-1:0]  tx_cnt_cur, rx_cnt_cur;
  logic [ACW-1:0] tx_sum, rx_sum;

  always_comb begin
    tx_cnt_cur = tx_cnt_i[idx_q*CW +: CW];
    rx_cnt_cur = rx_cnt_i[idx_q*CW +: CW];
    tx_sum = tx_acc_q + ACW'(tx_cnt_cur);
    rx_sum = rx_acc_q + ACW'(rx_cnt_cur);
  end

  // build FSM and table writes
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tx_acc_d  = tx_acc_q;
    rx_acc_d  = rx_acc_q;
    tx_base_d = tx_base_q;
    rx_base_d = rx_base_q;
`ifdef UDMA_CH_ALLOC_BOUNDS_EN
    tx_len_d  = tx_len_q;
    rx_len_d  = rx_len_q;
`endif
    tx_used_d = tx_used_q;
    rx_used_d = rx_used_q;
    if (rebuild_i) begin
      // rebuild wins over an in-flight slot write
      state_d  = BUILD;
      idx_d    = '0;
      tx_acc_d = '0;
      rx_acc_d = '0;
      for (int p = 0; p < N_PERIPHS; p++) begin
        tx_base_d[p] = '0;
        rx_base_d[p] = '0;
`ifdef UDMA_CH_ALLOC_BOUNDS_EN
        tx_len_d[p]  = '0;
        rx_len_d[p]  = '0;
`endif
      end
    end else begin
      unique case (state_q)
        BUILD: begin
          tx_base_d[idx_q] = IDW'(tx_acc_q);
          rx_base_d[idx_q] = IDW'(rx_acc_q);
`ifdef UDMA_CH_ALLOC_BOUNDS_EN
          tx_len_d[idx_q]  = tx_cnt_cur;
          rx_len_d[idx_q]  = rx_cnt_cur;
`endif
          tx_acc_d = tx_sum;
          rx_acc_d = rx_sum;
          if (idx_q == PW'(N_PERIPHS - 1)) begin
            idx_d     = '0;
            tx_used_d = UW'(tx_sum);
            rx_used_d = UW'(rx_sum);
            if (tx_sum > ACW'(N_TX_CH) ||
                rx_sum > ACW'(N_RX_CH))
              state_d = OVF;
            else
              state_d = READY;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        READY, OVF: begin
          state_d = state_q;
        end
        default: state_d = BUILD;
      endcase
    end
  end

  logic           accept;
  logic           per_ok;
  logic [PW-1:0]  per_idx;
  logic [IDW-1:0] base_sel;
`ifdef UDMA_CH_ALLOC_BOUNDS_EN
  logic [CW-1:0]  len_sel;
`endif

  // lookup path; reads the current table so a same-cycle rebuild
  // still serves from the old map
  always_comb begin
    accept   = req_valid_i && (state_q == READY);
    per_ok   = req_per_i < PW1'(N_PERIPHS);
    per_idx  = req_per_i[PW-1:0];
    base_sel = req_dir_i ? rx_base_q[per_idx]
                         : tx_base_q[per_idx];
`ifdef UDMA_CH_ALLOC_BOUNDS_EN
    len_sel  = req_dir_i ? rx_len_q[per_idx]
                         : tx_len_q[per_idx];
`endif
    rsp_valid_d = accept;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      if (!per_ok) begin
        rsp_id_d  = '0;
        rsp_err_d = 1'b1;
`ifdef UDMA_CH_ALLOC_BOUNDS_EN
      end else if (req_sub_i >= len_sel) begin
        rsp_id_d  = '0;
        rsp_err_d = 1'b1;
`endif
      end else begin
        rsp_id_d  = base_sel + IDW'(req_sub_i);
        rsp_err_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= BUILD;
      idx_q       <= '0;
      tx_acc_q    <= '0;
      rx_acc_q    <= '0;
      for (int p = 0; p < N_PERIPHS; p++) begin
        tx_base_q[p] <= '0;
        rx_base_q[p] <= '0;
`ifdef UDMA_CH_ALLOC_BOUNDS_EN
        tx_len_q[p]  <= '0;
        rx_len_q[p]  <= '0;
`endif
      end
      tx_used_q   <= '0;
      rx_used_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tx_acc_q    <= tx_acc_d;
      rx_acc_q    <= rx_acc_d;
      tx_base_q   <= tx_base_d;
      rx_base_q   <= rx_base_d;
`ifdef UDMA_CH_ALLOC_BOUNDS_EN
      tx_len_q    <= tx_len_d;
      rx_len_q    <= rx_len_d;
`endif
      tx_used_q   <= tx_used_d;
      rx_used_q   <= rx_used_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign busy_o      = (state_q == BUILD);
  assign map_ok_o    = (state_q == READY);
  assign ovf_o       = (state_q == OVF);
  assign req_ready_o = map_ok_o;
  assign tx_used_o   = tx_used_q;
  assign rx_used_o   = rx_used_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: doc/udma_ch_alloc.md
# udma_ch_alloc

Runtime channel-ID allocator for the uDMA core: replaces compile-time linear-channel ID constants with a table built in hardware from per-peripheral channel counts. After reset or a rebuild request, it walks the peripheral list one entry per cycle, assigning contiguous TX and RX linear-channel base IDs. It then serves single-cycle-latency lookups (peripheral, direction, sub-channel → channel ID) for the uDMA configuration interconnect and the drivers' ID-discovery registers.

## Interface

- N_PERIPHS, default 8: number of peripheral slots in the table.
- MAX_CH, default 4: maximum channels per peripheral per direction.
- N_TX_CH, default 16: TX linear channels physically available.
- N_RX_CH, default 16: RX linear channels physically available.
- CW = $clog2(MAX_CH+1) (derived): count width.
- IDW = $clog2(max(N_TX_CH,N_RX_CH)) (derived): channel-ID width.
- PW = $clog2(N_PERIPHS) (derived): peripheral-index width.

- clk_i  in  1  clock.
- rst_i  in  1  reset. Synchronous, active-high.
- tx_cnt_i  in  N_PERIPHS*CW  TX channel count per peripheral. Slot p is at [p*CW +: CW].
- rx_cnt_i  in  N_PERIPHS*CW  RX channel count per peripheral, same packing.
- rebuild_i  in  1  single-cycle pulse that restarts table construction.
- busy_o  out  1  table build in progress.
- map_ok_o  out  1  table valid and within capacity.
- ovf_o  out  1  last build exceeded N_TX_CH or N_RX_CH.
- tx_used_o  out  IDW+1  total TX channels allocated by the last build.
- rx_used_o  out  IDW+1  total RX channels allocated by the last build.
- req_valid_i  in  1  lookup request.
- req_ready_o  out  1  lookup accepted; equals map_ok_o.
- req_per_i  in  PW+1  peripheral index.
- req_dir_i  in  1  0 = TX, 1 = RX.
- req_sub_i  in  CW  sub-channel index within the peripheral.
- rsp_valid_o  out  1  response valid. One-cycle pulse; no backpressure.
- rsp_id_o  out  IDW  resolved channel ID.
- rsp_err_o  out  1  lookup error.

## Operation

- FSM states: BUILD, READY, OVF.
- Reset enters BUILD with idx=0, tx_acc=0, rx_acc=0. Every base and count entry is cleared to 0.
- Each BUILD cycle:
  - tx_base[idx]←tx_acc, rx_base[idx]←rx_acc.
  - tx_len[idx]←tx_cnt, rx_len[idx]←rx_cnt.
  - tx_acc+=tx_cnt[idx], rx_acc+=rx_cnt[idx].
  - idx++.
- Counts are sampled only in the cycle their slot is visited. Changing them afterwards has no effect until the next rebuild.
- Accumulators are IDW+2 bits wide, so they cannot wrap for legal parameters.
- After slot N_PERIPHS-1 the FSM exits BUILD:
  - to OVF if tx_acc>N_TX_CH or rx_acc>N_RX_CH;
  - otherwise to READY.
  - tx_used_o and rx_used_o load the accumulators on this exit.
- In READY or OVF, rebuild_i → BUILD on the next cycle: idx, accumulators and tables are cleared.
- rebuild_i during BUILD restarts from idx=0 with cleared accumulators.
- Status outputs:
  - busy_o = (state==BUILD).
  - map_ok_o = (state==READY).
  - ovf_o = (state==OVF).
- Lookup, accepted when req_valid_i && req_ready_o:
  - rsp_id_o = base[dir][per] + req_sub_i, truncated to IDW.
  - rsp_err_o=1 if req_per_i ≥ N_PERIPHS; in that case rsp_id_o=0.
- Requests while not ready are dropped: no response is generated.

## Timing

- Reset values:
  - busy_o=1; map_ok_o=0; ovf_o=0.
  - tx_used_o=0; rx_used_o=0.
  - rsp_valid_o=0; rsp_id_o=0; rsp_err_o=0.
- Build latency is exactly N_PERIPHS cycles from the first BUILD cycle. map_ok_o rises on the following cycle.
- Lookup latency is 1 cycle: the response registers update on the edge after acceptance. Back-to-back requests give back-to-back responses.
- rebuild_i in the same cycle as an accepted request: the request is served from the old table. req_ready_o is low from the next cycle.
- Reset asserted mid-build or mid-lookup: all state returns to reset values on that edge, and a pending response is discarded.

## Configuration

- UDMA_CH_ALLOC_BOUNDS_EN:
  - Defined: a lookup with req_sub_i ≥ len[dir][per] returns rsp_err_o=1, rsp_id_o=0. This covers peripherals with zero channels in that direction.
  - Undefined: the sub-index is unchecked. rsp_id_o = base+sub, and rsp_err_o reports only an out-of-range req_per_i.

## Test plan

- Build, N_PERIPHS=4:
  - Stimulus: tx counts {1,2,2,1}, rx counts {1,1,1,1}.
  - busy_o is high for exactly 4 cycles after reset release, then map_ok_o=1.
  - tx_used_o=6, rx_used_o=4.
  - Lookup per=2, dir=TX, sub=1 → rsp_id_o=4 one cycle later, rsp_err_o=0.
- Overflow:
  - Stimulus: tx counts sum to N_TX_CH+1.
  - ovf_o=1, map_ok_o=0, req_ready_o=0.
  - Requests produce no rsp_valid_o.
- Rebuild:
  - In READY, change rx count of slot 0 from 1 to 3, then pulse rebuild_i.
  - After N_PERIPHS cycles, RX lookup per=1 sub=0 → 3.
  - Pulsing rebuild_i again mid-build extends busy_o to N_PERIPHS cycles from that pulse.
- Bounds (macro defined):
  - per=3, dir=TX, sub=1 with count 1 → rsp_err_o=1, rsp_id_o=0.
  - Same request with the macro undefined → rsp_id_o=6, rsp_err_o=0.
- Invalid peripheral and reset:
  - req_per_i=N_PERIPHS → rsp_err_o=1.
  - rst_i asserted the cycle after a request → rsp_valid_o=0, and the build restarts from slot 0.
